// File: rtl/cfs_md_rx_arbiter_pkg.sv
// Shared types and width helpers for the MD_RX round-robin arbiter.
package cfs_md_rx_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Width of each per-requester statistics counter.
    localparam int CFS_ARB_CNT_W = 16;

    // Byte-offset field width for a given MD data width.
    function automatic int offset_w(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // Byte-count field width; one wider than the offset so a full word fits.
    function automatic int size_w(input int data_width);
        return $clog2(data_width / 8) + 1;
    endfunction

endpackage

// File: rtl/cfs_md_rx_arbiter_if.sv
// Bundle of the upstream requester lanes and the downstream aligner MD_RX port.
// slave  : the arbiter's view (consumes requests, drives the aligner side).
// master : the environment's view (requesters plus aligner).
interface cfs_md_rx_arbiter_if #(
    parameter int NUM_REQ         = 4,
    parameter int ALGN_DATA_WIDTH = 32
);
    import cfs_md_rx_arb_pkg::*;

    localparam int OFFSET_W = offset_w(ALGN_DATA_WIDTH);
    localparam int SIZE_W   = size_w(ALGN_DATA_WIDTH);

    // Upstream requester lanes, requester i at slice i.
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ*ALGN_DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ*OFFSET_W-1:0]        req_offset;
    logic [NUM_REQ*SIZE_W-1:0]          req_size;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0]                 req_err;

    // Downstream single MD_RX port towards the aligner.
    logic                               md_rx_valid;
    logic [ALGN_DATA_WIDTH-1:0]         md_rx_data;
    logic [OFFSET_W-1:0]                md_rx_offset;
    logic [SIZE_W-1:0]                  md_rx_size;
    logic                               md_rx_ready;
    logic                               md_rx_err;

    modport slave (
        input  req_valid, req_data, req_offset, req_size,
        output req_ready, req_err,
        output md_rx_valid, md_rx_data, md_rx_offset, md_rx_size,
        input  md_rx_ready, md_rx_err
    );

    modport master (
        output req_valid, req_data, req_offset, req_size,
        input  req_ready, req_err,
        input  md_rx_valid, md_rx_data, md_rx_offset, md_rx_size,
        output md_rx_ready, md_rx_err
    );

endinterface

// File: rtl/cfs_md_rx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first unmasked request found
// when searching last+1, last+2, ... (mod N).
module cfs_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     mask_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [N-1:0] cand;

    assign cand = req_i & ~mask_i;

    // Walk the ring once starting just after last_i; first hit wins.
    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 1; k <= N; k++) begin
            j = int'(last_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_o && cand[j[IDX_W-1:0]]) begin
                any_o                = 1'b1;
                idx_o                = j[IDX_W-1:0];
                gnt_o[j[IDX_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cfs_md_rx_arbiter.sv
// Round-robin arbiter sharing the aligner's single MD_RX port among NUM_REQ
// upstream MD masters. The grant is registered; the granted lane's
// data/offset/size are muxed combinationally and ready/err are routed back
// only to the granted lane.
// Optional build macro: CFS_MD_RX_ARB_STATS_EN adds per-requester saturating
// completion (xfer_cnt) and error (err_cnt) counters.
module cfs_md_rx_arbiter
    import cfs_md_rx_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int ALGN_DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    cfs_md_rx_arbiter_if.slave                bus,
    output logic [NUM_REQ-1:0]                grant,
    output logic                              busy
`ifdef CFS_MD_RX_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CFS_ARB_CNT_W-1:0]  xfer_cnt,
    output logic [NUM_REQ*CFS_ARB_CNT_W-1:0]  err_cnt
`endif
);

    localparam int OFFSET_W = offset_w(ALGN_DATA_WIDTH);
    localparam int SIZE_W   = size_w(ALGN_DATA_WIDTH);
    localparam int IDX_W    = $clog2(NUM_REQ);

    arb_state_e          state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [IDX_W-1:0]    gidx_q;
    logic [IDX_W-1:0]    last_q;
    logic                busy_q;

    // Unpacked views of the requester lanes so the mux is a plain index.
    logic [ALGN_DATA_WIDTH-1:0] data_a   [NUM_REQ];
    logic [OFFSET_W-1:0]        offset_a [NUM_REQ];
    logic [SIZE_W-1:0]          size_a   [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign data_a[gi]   = bus.req_data[gi*ALGN_DATA_WIDTH +: ALGN_DATA_WIDTH];
        assign offset_a[gi] = bus.req_offset[gi*OFFSET_W +: OFFSET_W];
        assign size_a[gi]   = bus.req_size[gi*SIZE_W +: SIZE_W];
    end

    logic g_valid;
    logic complete;

    assign g_valid  = bus.req_valid[gidx_q];
    assign complete = busy_q & g_valid & bus.md_rx_ready;

    // IDLE-time arbitration: all requests eligible, search after last winner.
    logic [NUM_REQ-1:0] idle_gnt;
    logic [IDX_W-1:0]   idle_idx;
    logic               idle_any;

    cfs_rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick_idle (
        .req_i  (bus.req_valid),
        .mask_i ({NUM_REQ{1'b0}}),
        .last_i (last_q),
        .gnt_o  (idle_gnt),
        .idx_o  (idle_idx),
        .any_o  (idle_any)
    );

    // Completion-time arbitration: current owner masked so a repeating
    // requester yields one idle cycle while a different one follows at once.
    logic [NUM_REQ-1:0] next_gnt;
    logic [IDX_W-1:0]   next_idx;
    logic               next_any;

    cfs_rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick_next (
        .req_i  (bus.req_valid),
        .mask_i (grant_q),
        .last_i (gidx_q),
        .gnt_o  (next_gnt),
        .idx_o  (next_idx),
        .any_o  (next_any)
    );

    // Arbiter FSM with registered grant/busy outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (idle_any) begin
                        state_q <= ARB_BUSY;
                        grant_q <= idle_gnt;
                        gidx_q  <= idle_idx;
                        busy_q  <= 1'b1;
                    end
                end
                ARB_BUSY: begin
                    if (complete) begin
                        last_q <= gidx_q;
                        if (next_any) begin
                            grant_q <= next_gnt;
                            gidx_q  <= next_idx;
                        end else begin
                            state_q <= ARB_IDLE;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                        end
                    end else if (!g_valid) begin
                        // Owner withdrew without completing: abandon silently.
                        state_q <= ARB_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;

    assign bus.md_rx_valid  = busy_q & g_valid;
    assign bus.md_rx_data   = busy_q ? data_a[gidx_q]   : '0;
    assign bus.md_rx_offset = busy_q ? offset_a[gidx_q] : '0;
    assign bus.md_rx_size   = busy_q ? size_a[gidx_q]   : '0;

    assign bus.req_ready = complete ? grant_q : '0;
    assign bus.req_err   = (complete && bus.md_rx_err) ? grant_q : '0;

`ifdef CFS_MD_RX_ARB_STATS_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
        logic [CFS_ARB_CNT_W-1:0] xfer_q, xfer_d;
        logic [CFS_ARB_CNT_W-1:0] err_q, err_d;
        logic                     hit;

        assign hit = complete & grant_q[gi];

        // Saturating increments on this lane's completions.
        always_comb begin
            xfer_d = xfer_q;
            err_d  = err_q;
            if (hit && (xfer_q != '1)) begin
                xfer_d = xfer_q + 1'b1;
            end
            if (hit && bus.md_rx_err && (err_q != '1)) begin
                err_d = err_q + 1'b1;
            end
        end

        // Counter registers, cleared by reset.
        always_ff @(posedge clk) begin
            if (reset) begin
                xfer_q <= '0;
                err_q  <= '0;
            end else begin
                xfer_q <= xfer_d;
                err_q  <= err_d;
            end
        end

        assign xfer_cnt[gi*CFS_ARB_CNT_W +: CFS_ARB_CNT_W] = xfer_q;
        assign err_cnt[gi*CFS_ARB_CNT_W +: CFS_ARB_CNT_W]  = err_q;
    end
`endif

endmodule

// File: tb/tb_cfs_md_rx_arbiter.sv
// Self-checking bench for cfs_md_rx_arbiter: directed scenarios with literal
// expectations plus a long randomized run, all outputs compared every cycle
// against a transaction-level round-robin model.
module tb_cfs_md_rx_arbiter;
    import cfs_md_rx_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int OW = offset_w(DW);
    localparam int SW = size_w(DW);

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] grant;
    logic         busy;
`ifdef CFS_MD_RX_ARB_STATS_EN
    logic [N*16-1:0] xfer_cnt;
    logic [N*16-1:0] err_cnt;
`endif

    cfs_md_rx_arbiter_if #(.NUM_REQ(N), .ALGN_DATA_WIDTH(DW)) bus ();

    cfs_md_rx_arbiter #(.NUM_REQ(N), .ALGN_DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .grant    (grant),
        .busy     (busy)
`ifdef CFS_MD_RX_ARB_STATS_EN
        ,
        .xfer_cnt (xfer_cnt),
        .err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner = requester currently holding the port (-1 when none);
    // last  = requester that completed most recently.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_xfer [N];
    int m_errc [N];

    function automatic int rr_first(input logic [N-1:0] v, input int after);
        for (int k = 1; k <= N; k++) begin
            if (v[(after + k) % N]) return (after + k) % N;
        end
        return -1;
    endfunction

    // Compare every output against the model, then advance the model.
    always @(negedge clk) begin
        logic [N-1:0]  v, v2, e_grant, e_rdy, e_err;
        logic [DW-1:0] e_data;
        logic [OW-1:0] e_off;
        logic [SW-1:0] e_size;
        logic          e_valid, done;
        v       = bus.req_valid;
        e_grant = '0;
        e_rdy   = '0;
        e_err   = '0;
        e_data  = '0;
        e_off   = '0;
        e_size  = '0;
        e_valid = 1'b0;
        done    = 1'b0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_valid = v[m_owner];
            e_data  = bus.req_data[m_owner*DW +: DW];
            e_off   = bus.req_offset[m_owner*OW +: OW];
            e_size  = bus.req_size[m_owner*SW +: SW];
            done    = v[m_owner] && bus.md_rx_ready;
            if (done) begin
                e_rdy[m_owner] = 1'b1;
                e_err[m_owner] = bus.md_rx_err;
            end
        end
        chk("grant",        grant,            e_grant);
        chk("busy",         busy,             m_owner >= 0);
        chk("md_rx_valid",  bus.md_rx_valid,  e_valid);
        chk("md_rx_data",   bus.md_rx_data,   e_data);
        chk("md_rx_offset", bus.md_rx_offset, e_off);
        chk("md_rx_size",   bus.md_rx_size,   e_size);
        chk("req_ready",    bus.req_ready,    e_rdy);
        chk("req_err",      bus.req_err,      e_err);
`ifdef CFS_MD_RX_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            chk("xfer_cnt", xfer_cnt[i*16 +: 16], m_xfer[i]);
            chk("err_cnt",  err_cnt[i*16 +: 16],  m_errc[i]);
        end
`endif
        if (done) begin
            $display("xfer req=%0d data=%08h off=%0d size=%0d err=%0d",
                     m_owner, e_data, e_off, e_size, bus.md_rx_err);
        end
        if (reset) begin
            m_owner = -1;
            m_last  = N - 1;
            for (int i = 0; i < N; i++) begin
                m_xfer[i] = 0;
                m_errc[i] = 0;
            end
        end else if (m_owner < 0) begin
            m_owner = rr_first(v, m_last);
        end else if (done) begin
            if (m_xfer[m_owner] < 65535) m_xfer[m_owner]++;
            if (bus.md_rx_err && m_errc[m_owner] < 65535) m_errc[m_owner]++;
            m_last = m_owner;
            v2 = v;
            v2[m_owner] = 1'b0;
            m_owner = rr_first(v2, m_owner);
        end else if (!v[m_owner]) begin
            m_owner = -1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        bus.req_valid   = '0;
        bus.req_data    = '0;
        bus.req_offset  = '0;
        bus.req_size    = '0;
        bus.md_rx_ready = 1'b0;
        bus.md_rx_err   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        clear_inputs();
        step();
        reset = 1'b0;
    endtask

    task automatic set_lane(input int i, input logic [DW-1:0] d,
                            input logic [OW-1:0] o, input logic [SW-1:0] s);
        bus.req_valid[i]               = 1'b1;
        bus.req_data[i*DW +: DW]       = d;
        bus.req_offset[i*OW +: OW]     = o;
        bus.req_size[i*SW +: SW]       = s;
    endtask

    logic [N-1:0] exp_v;
    logic [N-1:0] ack;

    initial begin
        clear_inputs();

        // Reset state.
        @(negedge clk);
        chk("reset grant",     grant,           4'b0000);
        chk("reset busy",      busy,            1'b0);
        chk("reset md_valid",  bus.md_rx_valid, 1'b0);
        chk("reset req_ready", bus.req_ready,   4'b0000);

        // Single request on lane 2, aligner ready three cycles after grant.
        do_reset();
        set_lane(2, 32'hA5A5_0001, 2'd1, 3'd2);
        @(negedge clk);
        chk("t1 grant pre",   grant, 4'b0000);
        @(negedge clk);
        chk("t1 grant",       grant,            4'b0100);
        chk("t1 data",        bus.md_rx_data,   32'hA5A5_0001);
        chk("t1 offset",      bus.md_rx_offset, 2'd1);
        chk("t1 size",        bus.md_rx_size,   3'd2);
        step();
        step();
        bus.md_rx_ready = 1'b1;
        @(negedge clk);
        chk("t1 req_ready",   bus.req_ready, 4'b0100);
        chk("t1 busy",        busy,          1'b1);
        step();
        clear_inputs();
        @(negedge clk);
        chk("t1 ready pulse", bus.req_ready, 4'b0000);
        chk("t1 busy fall",   busy,          1'b0);

        // All four valid, aligner always ready: strict rotation, no bubbles.
        do_reset();
        for (int i = 0; i < N; i++) set_lane(i, $urandom, OW'($urandom), SW'($urandom));
        bus.md_rx_ready = 1'b1;
        @(negedge clk);
        chk("t2 idle", bus.req_ready, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_v = 4'b0001 << (k % N);
            chk("t2 rotation", bus.req_ready, exp_v);
        end
        step();
        clear_inputs();

        // Error routed only to the granted requester.
        do_reset();
        set_lane(1, 32'h0000_1111, 2'd0, 3'd4);
        @(negedge clk);
        step();
        bus.md_rx_ready = 1'b1;
        bus.md_rx_err   = 1'b1;
        @(negedge clk);
        chk("t3 req_err",   bus.req_err,   4'b0010);
        chk("t3 req_ready", bus.req_ready, 4'b0010);
        step();
        clear_inputs();
        @(negedge clk);
        chk("t3 err gone",  bus.req_err,   4'b0000);

        // Same requester repeating: one idle cycle between transfers.
        do_reset();
        set_lane(3, 32'h3333_0000, 2'd3, 3'd1);
        bus.md_rx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t4 busy", busy, (k % 2) == 1);
            exp_v = ((k % 2) == 1) ? 4'b1000 : 4'b0000;
            chk("t4 ready", bus.req_ready, exp_v);
        end
        step();
        clear_inputs();

        // Reset while requester 0 waits on ready.
        do_reset();
        set_lane(0, 32'h0BAD_F00D, 2'd2, 3'd3);
        @(negedge clk);
        @(negedge clk);
        chk("t5 busy before", busy,  1'b1);
        chk("t5 grant before", grant, 4'b0001);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_lane(3, 32'h3000_0003, 2'd0, 3'd4);
        @(negedge clk);
        chk("t5 busy after",  busy,          1'b0);
        chk("t5 grant after", grant,         4'b0000);
        chk("t5 no ready",    bus.req_ready, 4'b0000);
        @(negedge clk);
        chk("t5 priority",    grant,         4'b0001);
        step();
        clear_inputs();

`ifdef CFS_MD_RX_ARB_STATS_EN
        // Five completions on requester 1, the first two flagged with err.
        do_reset();
        for (int t = 0; t < 5; t++) begin
            set_lane(1, DW'(t), 2'd0, 3'd4);
            bus.md_rx_ready = 1'b1;
            bus.md_rx_err   = (t < 2);
            @(negedge clk);
            @(negedge clk);
            step();
            clear_inputs();
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("t6 xfer_cnt", xfer_cnt[i*16 +: 16], (i == 1) ? 16'd5 : 16'd0);
            chk("t6 err_cnt",  err_cnt[i*16 +: 16],  (i == 1) ? 16'd2 : 16'd0);
        end
`endif

        // Randomized traffic: requesters mostly hold until acked, with rare
        // withdrawals and resets; the model checks every cycle.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ack = bus.req_ready;
            step();
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i]) begin
                    if (ack[i]) begin
                        if ($urandom_range(0, 1) == 1)
                            set_lane(i, $urandom, OW'($urandom), SW'($urandom));
                        else
                            bus.req_valid[i] = 1'b0;
                    end else if ($urandom_range(0, 49) == 0) begin
                        bus.req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 9) < 3) begin
                    set_lane(i, $urandom, OW'($urandom), SW'($urandom));
                end
            end
            bus.md_rx_ready = ($urandom_range(0, 9) < 5);
            bus.md_rx_err   = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
